// File: rtl/lsu_mem_access.sv
// Load/store stage: forwards non-memory ops, runs one request at a time on the memory bus,
// aligns store data/strobes and extracts sign/zero-extended load data for writeback.
module lsu_mem_access #(
    parameter int TIMEOUT    = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_wdata,
    input  logic                  in_mem_ren,
    input  logic                  in_mem_wen,
    input  logic [3:0]            in_wmask,
    input  logic [2:0]            in_load_ctrl,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_wen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_result,
    output logic [4:0]            out_rd,
    output logic                  out_reg_wen,
    output logic                  out_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [31:0]           mem_req_wdata,
    output logic [3:0]            mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_rdata,
    input  logic                  mem_resp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] LC_LB  = 3'b000;
    localparam logic [2:0] LC_LH  = 3'b001;
    localparam logic [2:0] LC_LBU = 3'b100;
    localparam logic [2:0] LC_LHU = 3'b101;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [4:0]            r_rd;
    logic                  r_reg_wen;
    logic                  r_is_store;
    logic [1:0]            r_byte_off;
    logic [2:0]            r_load_ctrl;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic                  r_req_wen;
    logic [31:0]           r_req_wdata;
    logic [3:0]            r_req_wstrb;
    logic [31:0]           r_out_result;
    logic                  r_out_err;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_half;
    logic        w_word;
    logic        w_misaligned;
    logic        w_busy;
    logic        w_resp;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign w_accept     = in_valid & in_ready;
    assign w_is_mem     = in_mem_ren | in_mem_wen;
    // Access size comes from the strobe mask for stores and from funct3 for loads.
    assign w_word       = in_mem_wen ? (in_wmask == 4'b1111) : (in_load_ctrl[1:0] == 2'b10);
    assign w_half       = in_mem_wen ? (in_wmask == 4'b0011) : (in_load_ctrl[1:0] == 2'b01);
    assign w_misaligned = (w_half & in_addr[0]) | (w_word & (in_addr[1:0] != 2'b00));
    assign w_busy       = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_resp       = w_busy & mem_resp_valid;
    assign w_timeout    = w_busy & ~mem_resp_valid & (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: defaulting first means no path through the case leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_mem)        w_next_state = S_PASS;
                    else if (w_misaligned) w_next_state = S_DONE;
                    else                   w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (w_resp || w_timeout) w_next_state = S_DONE;
                else if (mem_req_ready)  w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_resp || w_timeout) w_next_state = S_DONE;
            end
            S_PASS, S_DONE: begin
                if (out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (r_state == S_IDLE);
        out_valid     = (r_state == S_PASS) || (r_state == S_DONE);
        mem_req_valid = (r_state == S_REQ);
    end

    assign w_shifted = mem_resp_rdata >> {r_byte_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_load_ctrl)
            LC_LB:   w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LC_LH:   w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LC_LBU:  w_load_data = {24'h0, w_shifted[7:0]};
            LC_LHU:  w_load_data = {16'h0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // NOTE: the datapath is reset too, so out_* and mem_req_* read as zero straight after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_rd         <= '0;
            r_reg_wen    <= 1'b0;
            r_is_store   <= 1'b0;
            r_byte_off   <= '0;
            r_load_ctrl  <= '0;
            r_req_addr   <= '0;
            r_req_wen    <= 1'b0;
            r_req_wdata  <= '0;
            r_req_wstrb  <= '0;
            r_out_result <= '0;
            r_out_err    <= 1'b0;
        end else if (w_accept) begin
            r_rd        <= in_rd;
            r_reg_wen   <= in_reg_wen;
            r_is_store  <= in_mem_wen;
            r_byte_off  <= in_addr[1:0];
            r_load_ctrl <= in_load_ctrl;
            r_cnt       <= '0;
            if (!w_is_mem) begin
                r_out_result <= 32'(in_addr);
                r_out_err    <= 1'b0;
            end else if (w_misaligned) begin
                r_out_result <= '0;
                r_out_err    <= 1'b1;
            end else begin
                r_req_addr   <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                r_req_wen    <= in_mem_wen;
                r_req_wdata  <= in_wdata << {in_addr[1:0], 3'b000};
                r_req_wstrb  <= in_mem_wen ? (in_wmask << in_addr[1:0]) : 4'b0000;
                r_out_result <= '0;
                r_out_err    <= 1'b0;
            end
        end else if (w_busy) begin
            if (w_resp) begin
                r_out_result <= r_is_store ? 32'h0 : w_load_data;
                r_out_err    <= mem_resp_err;
                r_cnt        <= '0;
            end else if (w_timeout) begin
                r_out_result <= '0;
                r_out_err    <= 1'b1;
                r_cnt        <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign mem_req_addr  = r_req_addr;
    assign mem_req_wen   = r_req_wen;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wstrb = r_req_wstrb;
    assign out_result    = r_out_result;
    assign out_rd        = r_rd;
    assign out_err       = r_out_err;
    assign out_reg_wen   = r_reg_wen & ~r_out_err;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed scenarios plus randomized ops against a
// byte-arithmetic reference model; one task per scenario.
module tb_lsu_mem_access;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_mem_ren = 1'b0;
    logic        in_mem_wen = 1'b0;
    logic [3:0]  in_wmask = '0;
    logic [2:0]  in_load_ctrl = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_wen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_wen;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        mem_resp_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_mem_access #(.TIMEOUT(TO), .ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_wmask(in_wmask),
        .in_load_ctrl(in_load_ctrl), .in_rd(in_rd), .in_reg_wen(in_reg_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_reg_wen(out_reg_wen), .out_err(out_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
    );

    always #5 clock = ~clock;

    // Observations gathered by run_op for the scenario tasks to judge.
    int          c_cyc;
    int          c_lat;
    logic        c_req_seen, c_req_stable, c_out_stable, c_in_ready_bad;
    logic        c_out_valid, c_in_ready_after, c_out_valid_after;
    logic [31:0] c_req_addr, c_req_wdata, c_result;
    logic        c_req_wen, c_reg_wen, c_err;
    logic [3:0]  c_req_wstrb;
    logic [4:0]  c_rd;

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic wen, input logic [3:0] wmask, input logic [2:0] lc);
        if (wen) return (wmask == 4'hF) ? 4 : (wmask == 4'h3) ? 2 : 1;
        case (lc)
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off, input logic [2:0] lc);
        longint w, v, span;
        int     n;
        bit     sgn;
        n    = acc_bytes(1'b0, 4'h0, lc);
        sgn  = (lc == 3'b000) || (lc == 3'b001);
        span = longint'(1) << (8 * n);
        w    = {32'h0, rdata};
        v    = (w / (longint'(1) << (8 * off))) % span;
        if (sgn && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clock);
        c_cyc++;
        if (in_ready) c_in_ready_bad = 1'b1;
        if (mem_req_valid) c_req_seen = 1'b1;
    endtask

    task automatic run_op(input logic [31:0] addr, input logic [31:0] wdata, input logic ren,
                          input logic wen, input logic [3:0] wmask, input logic [2:0] lc,
                          input logic [4:0] rd, input logic reg_wen, input int req_wait,
                          input int resp_wait, input logic respond, input logic [31:0] rdata,
                          input logic rerr, input int out_wait, input logic late_resp);
        c_cyc = 0; c_lat = 0; c_req_seen = 1'b0; c_req_stable = 1'b1; c_out_stable = 1'b1;
        c_in_ready_bad = 1'b0; c_out_valid = 1'b0; c_in_ready_after = 1'b0; c_out_valid_after = 1'b1;
        in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_mem_ren = ren; in_mem_wen = wen;
        in_wmask = wmask; in_load_ctrl = lc; in_rd = rd; in_reg_wen = reg_wen;
        step();
        in_valid = 1'b0; in_addr = $urandom(); in_wdata = $urandom(); in_mem_ren = 1'b0;
        in_mem_wen = 1'b0; in_wmask = 4'($urandom()); in_rd = 5'($urandom()); in_reg_wen = 1'($urandom());
        while (!mem_req_valid && !out_valid && c_cyc < 40) step();
        if (mem_req_valid) begin
            c_req_addr = mem_req_addr; c_req_wen = mem_req_wen;
            c_req_wdata = mem_req_wdata; c_req_wstrb = mem_req_wstrb;
            for (int i = 0; i < req_wait; i++) begin
                step();
                if (!mem_req_valid || mem_req_addr !== c_req_addr || mem_req_wen !== c_req_wen ||
                    mem_req_wdata !== c_req_wdata || mem_req_wstrb !== c_req_wstrb)
                    c_req_stable = 1'b0;
            end
            mem_req_ready = 1'b1;
            if (respond && resp_wait == 0) begin
                mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_resp_err = rerr;
            end
            step();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            if (respond && resp_wait > 0) begin
                for (int i = 1; i < resp_wait; i++) step();
                mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_resp_err = rerr;
                step();
                mem_resp_valid = 1'b0;
            end
        end
        while (!out_valid && c_cyc < 40) step();
        c_lat = c_cyc; c_out_valid = out_valid; c_result = out_result;
        c_rd = out_rd; c_reg_wen = out_reg_wen; c_err = out_err;
        if (out_valid) begin
            for (int i = 0; i < out_wait; i++) begin
                if (late_resp && i == 0) begin
                    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF; mem_resp_err = 1'b0;
                end
                step();
                mem_resp_valid = 1'b0;
                if (!out_valid || out_result !== c_result || out_rd !== c_rd ||
                    out_reg_wen !== c_reg_wen || out_err !== c_err)
                    c_out_stable = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
            c_in_ready_after = in_ready; c_out_valid_after = out_valid;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
        n_tests++; if ({out_result, out_rd, out_err, out_reg_wen} !== 39'h0) begin
            n_fail++; $display("FAIL reset_out_payload got %h/%0d/%b/%b want 0", out_result, out_rd, out_err, out_reg_wen); end
        n_tests++; if ({mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen} !== 69'h0) begin
            n_fail++; $display("FAIL reset_req_payload got %h/%h/%b/%b want 0", mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen); end
        reset = 1'b1;
        @(negedge clock);
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_pass_through();
        run_op(32'h1234_5678, 32'h0, 1'b0, 1'b0, 4'h0, 3'b000, 5'd5, 1'b1, 0, 0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
        n_tests++; if (c_lat !== 1) begin n_fail++; $display("FAIL pass_latency got %0d want 1", c_lat); end
        n_tests++; if (c_result !== 32'h1234_5678) begin n_fail++; $display("FAIL pass_result got %h want 12345678", c_result); end
        n_tests++; if (c_rd !== 5'd5) begin n_fail++; $display("FAIL pass_rd got %0d want 5", c_rd); end
        n_tests++; if (c_reg_wen !== 1'b1 || c_err !== 1'b0) begin
            n_fail++; $display("FAIL pass_wen_err got %b/%b want 1/0", c_reg_wen, c_err); end
        n_tests++; if (c_req_seen !== 1'b0) begin n_fail++; $display("FAIL pass_no_bus got %b want 0", c_req_seen); end
        n_tests++; if (c_in_ready_after !== 1'b1) begin n_fail++; $display("FAIL pass_return_idle got %b want 1", c_in_ready_after); end
    endtask

    task automatic test_byte_store();
        run_op(32'h8000_0003, 32'h0000_00AB, 1'b0, 1'b1, 4'b0001, 3'b000, 5'd0, 1'b0, 0, 0, 1'b1, 32'h5555_5555, 1'b0, 0, 1'b0);
        n_tests++; if (c_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL sb_addr got %h want 80000000", c_req_addr); end
        n_tests++; if (c_req_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb got %b want 1000", c_req_wstrb); end
        n_tests++; if (c_req_wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_wdata got %h want ab000000", c_req_wdata); end
        n_tests++; if (c_req_wen !== 1'b1) begin n_fail++; $display("FAIL sb_wen got %b want 1", c_req_wen); end
        n_tests++; if (c_lat !== 2) begin n_fail++; $display("FAIL sb_min_latency got %0d want 2", c_lat); end
        n_tests++; if (c_result !== 32'h0 || c_err !== 1'b0) begin
            n_fail++; $display("FAIL sb_result got %h/%b want 0/0", c_result, c_err); end
    endtask

    task automatic test_load_extend();
        run_op(32'h1000_0002, 32'h0, 1'b1, 1'b0, 4'h0, 3'b000, 5'd7, 1'b1, 0, 0, 1'b1, 32'h00F0_0000, 1'b0, 0, 1'b0);
        n_tests++; if (c_result !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb_result got %h want fffffff0", c_result); end
        n_tests++; if (c_req_wstrb !== 4'b0000 || c_req_wen !== 1'b0) begin
            n_fail++; $display("FAIL lb_read_req got %b/%b want 0000/0", c_req_wstrb, c_req_wen); end
        run_op(32'h1000_0002, 32'h0, 1'b1, 1'b0, 4'h0, 3'b100, 5'd7, 1'b1, 0, 1, 1'b1, 32'h00F0_0000, 1'b0, 0, 1'b0);
        n_tests++; if (c_result !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu_result got %h want 000000f0", c_result); end
        n_tests++; if (c_reg_wen !== 1'b1 || c_rd !== 5'd7) begin
            n_fail++; $display("FAIL lbu_wb got %b/%0d want 1/7", c_reg_wen, c_rd); end
    endtask

    task automatic test_misaligned();
        run_op(32'h4000_0001, 32'h0, 1'b1, 1'b0, 4'h0, 3'b010, 5'd9, 1'b1, 0, 0, 1'b1, 32'h0, 1'b0, 1, 1'b0);
        n_tests++; if (c_req_seen !== 1'b0) begin n_fail++; $display("FAIL mis_no_bus got %b want 0", c_req_seen); end
        n_tests++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b want 1", c_err); end
        n_tests++; if (c_reg_wen !== 1'b0) begin n_fail++; $display("FAIL mis_reg_wen got %b want 0", c_reg_wen); end
        n_tests++; if (c_lat !== 1) begin n_fail++; $display("FAIL mis_latency got %0d want 1", c_lat); end
    endtask

    task automatic test_back_pressure();
        run_op(32'h2000_0006, 32'h0, 1'b1, 1'b0, 4'h0, 3'b101, 5'd3, 1'b1, 5, 1, 1'b1, 32'hBEEF_1234, 1'b0, 3, 1'b0);
        n_tests++; if (c_req_stable !== 1'b1) begin n_fail++; $display("FAIL bp_req_held got %b want 1", c_req_stable); end
        n_tests++; if (c_out_stable !== 1'b1) begin n_fail++; $display("FAIL bp_out_held got %b want 1", c_out_stable); end
        n_tests++; if (c_in_ready_bad !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low got %b want 0", c_in_ready_bad); end
        n_tests++; if (c_req_addr !== 32'h2000_0004) begin n_fail++; $display("FAIL bp_addr got %h want 20000004", c_req_addr); end
        n_tests++; if (c_result !== 32'h0000_BEEF) begin n_fail++; $display("FAIL bp_lhu_result got %h want 0000beef", c_result); end
        n_tests++; if (c_lat !== 8) begin n_fail++; $display("FAIL bp_latency got %0d want 8", c_lat); end
    endtask

    task automatic test_timeout();
        run_op(32'h3000_0008, 32'h0, 1'b1, 1'b0, 4'h0, 3'b010, 5'd4, 1'b1, 2, 0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
        n_tests++; if (c_lat !== 1 + TO) begin n_fail++; $display("FAIL to_latency got %0d want %0d", c_lat, 1 + TO); end
        n_tests++; if (c_err !== 1'b1 || c_reg_wen !== 1'b0) begin
            n_fail++; $display("FAIL to_err got %b/%b want 1/0", c_err, c_reg_wen); end
        n_tests++; if (c_out_stable !== 1'b1) begin n_fail++; $display("FAIL to_late_resp_ignored got %b want 1", c_out_stable); end
        n_tests++; if (c_in_ready_after !== 1'b1 || c_out_valid_after !== 1'b0) begin
            n_fail++; $display("FAIL to_return_idle got %b/%b want 1/0", c_in_ready_after, c_out_valid_after); end
    endtask

    task automatic test_reset_mid_op();
        in_valid = 1'b1; in_addr = 32'h5000_0000; in_mem_ren = 1'b1; in_mem_wen = 1'b0;
        in_load_ctrl = 3'b010; in_rd = 5'd1; in_reg_wen = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        n_tests++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req_issued got %b want 1", mem_req_valid); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_async_drop got %b want 0", mem_req_valid); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_wait got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        in_mem_ren = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, rdata, exp_result, exp_wdata;
        logic [2:0]  lc;
        logic [3:0]  wmask, exp_wstrb;
        logic [4:0]  rd;
        logic        ren, wen, reg_wen, rerr, mis, exp_req, exp_err;
        int          kind, n, off, rq, rs, ow;
        logic [2:0]  lcs [5];
        logic [3:0]  masks [3];
        lcs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        masks = '{4'b0001, 4'b0011, 4'b1111};
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 2);
            ren = (kind == 1); wen = (kind == 2);
            addr = $urandom(); wdata = $urandom(); rdata = $urandom();
            lc = lcs[$urandom_range(0, 4)]; wmask = masks[$urandom_range(0, 2)];
            rd = 5'($urandom()); reg_wen = 1'($urandom());
            rerr = ($urandom_range(0, 7) == 0);
            rq = $urandom_range(0, 3); rs = $urandom_range(0, 3); ow = $urandom_range(0, 2);
            n = acc_bytes(wen, wmask, lc);
            if (kind != 0 && $urandom_range(0, 3) != 0) addr = addr - (addr % n);
            off = int'(addr % 4);
            mis = (kind != 0) && (addr % n != 0);
            exp_req = (kind != 0) && !mis;
            exp_err = mis ? 1'b1 : (exp_req ? rerr : 1'b0);
            exp_result = (kind == 0) ? addr : (ren && !mis) ? model_load(rdata, off, lc) : 32'h0;
            exp_wdata = 32'(({32'h0, wdata} * (longint'(1) << (8 * off))) % (longint'(1) << 32));
            exp_wstrb = wen ? 4'((wmask * (1 << off)) % 16) : 4'h0;
            run_op(addr, wdata, ren, wen, wmask, lc, rd, reg_wen, rq, rs, 1'b1, rdata, rerr, ow, 1'b0);
            n_tests++; if (c_out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_out_valid got %b want 1", k, c_out_valid); end
            n_tests++; if (c_req_seen !== exp_req) begin n_fail++; $display("FAIL rnd%0d_bus_req got %b want %b", k, c_req_seen, exp_req); end
            n_tests++; if (c_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err got %b want %b", k, c_err, exp_err); end
            n_tests++; if (c_reg_wen !== (reg_wen & ~exp_err) || c_rd !== rd) begin
                n_fail++; $display("FAIL rnd%0d_wb got %b/%0d want %b/%0d", k, c_reg_wen, c_rd, reg_wen & ~exp_err, rd); end
            n_tests++; if (c_lat !== (exp_req ? 2 + rq + rs : 1)) begin
                n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", k, c_lat, exp_req ? 2 + rq + rs : 1); end
            n_tests++; if (c_out_stable !== 1'b1 || c_in_ready_bad !== 1'b0 || c_in_ready_after !== 1'b1) begin
                n_fail++; $display("FAIL rnd%0d_handshake got %b/%b/%b want 1/0/1", k, c_out_stable, c_in_ready_bad, c_in_ready_after); end
            if (!mis) begin
                n_tests++; if (c_result !== exp_result) begin
                    n_fail++; $display("FAIL rnd%0d_result got %h want %h (lc=%b addr=%h rdata=%h)", k, c_result, exp_result, lc, addr, rdata); end
            end
            if (exp_req) begin
                n_tests++; if (c_req_addr !== {addr[31:2], 2'b00} || c_req_wen !== wen || c_req_wstrb !== exp_wstrb) begin
                    n_fail++; $display("FAIL rnd%0d_req got %h/%b/%b want %h/%b/%b", k, c_req_addr, c_req_wen, c_req_wstrb, {addr[31:2], 2'b00}, wen, exp_wstrb); end
                if (wen) begin
                    n_tests++; if (c_req_wdata !== exp_wdata) begin
                        n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", k, c_req_wdata, exp_wdata); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_byte_store();
        test_load_extend();
        test_misaligned();
        test_back_pressure();
        test_timeout();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
